// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer.
//   state_t          : controller states (IDLE, RUN)
//   TICKS_W_DEFAULT  : default width of load value / remaining count
package tick_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned TICKS_W_DEFAULT = 16;

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter holding the timer's remaining tick count.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : load count from load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one; saturates at zero
//   count       : current count (registered)
//   zero_next   : count == 1, i.e. the next decrement reaches zero
module tick_downcounter
  import tick_timer_pkg::*;
#(
  parameter int unsigned W = TICKS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_next
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_next = (count == W'(1));

endmodule

// File: rtl/tick_timer.sv
// Prescaler-driven countdown timer with one-shot and auto-reload modes.
//   clk, reset  : clock, asynchronous active-high reset
//   tick        : one decrement per single-cycle pulse while running
//   start       : load and arm from load_value (retrigger while running)
//   stop        : abort a running timer without expiry
//   periodic    : mode sampled with start (1 = auto-reload, 0 = one-shot)
//   load_value  : ticks to expiry, sampled with start
//   irq_clear   : clears irq and missed
//   busy        : high while running
//   remaining   : ticks left before expiry
//   expired     : one-cycle pulse after the expiring tick
//   irq         : sticky expiry flag
//   missed      : sticky flag, expiry while irq already pending
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned TICKS_W = TICKS_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [TICKS_W-1:0] load_value,
  input  logic               irq_clear,
  output logic               busy,
  output logic [TICKS_W-1:0] remaining,
  output logic               expired,
  output logic               irq,
  output logic               missed
);

  state_t             state, next_state;
  logic [TICKS_W-1:0] reload;
  logic               mode;

  logic               cnt_load;
  logic [TICKS_W-1:0] cnt_value;
  logic               cnt_dec;
  logic               zero_next;
  logic               latch;
  logic               expire;

  tick_downcounter #(
    .W (TICKS_W)
  ) u_count (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .count      (remaining),
    .zero_next  (zero_next)
  );

  // Priority in RUN: stop (or zero-length retrigger) > start > tick.
  // An expiring tick reloads the counter directly instead of decrementing,
  // so periodic mode has no dead cycle and the count never wraps.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    cnt_dec    = 1'b0;
    latch      = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (load_value != '0)) begin
          next_state = RUN;
          cnt_load   = 1'b1;
          cnt_value  = load_value;
          latch      = 1'b1;
        end
      end
      RUN: begin
        if (stop || (start && (load_value == '0))) begin
          next_state = IDLE;
          cnt_load   = 1'b1;
        end else if (start) begin
          cnt_load  = 1'b1;
          cnt_value = load_value;
          latch     = 1'b1;
        end else if (tick) begin
          if (zero_next) begin
            expire   = 1'b1;
            cnt_load = 1'b1;
            if (mode) begin
              cnt_value = reload;
            end else begin
              next_state = IDLE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      reload  <= '0;
      mode    <= 1'b0;
      expired <= 1'b0;
      irq     <= 1'b0;
      missed  <= 1'b0;
    end else begin
      state   <= next_state;
      expired <= expire;
      if (latch) begin
        reload <= load_value;
        mode   <= periodic;
      end
      // Set wins over clear for irq.
      if (expire) begin
        irq <= 1'b1;
      end else if (irq_clear) begin
        irq <= 1'b0;
      end
      // A coincident expiry and clear leaves missed as it was.
      if (expire && irq && !irq_clear) begin
        missed <= 1'b1;
      end else if (irq_clear && !expire) begin
        missed <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, start, stop, periodic, irq_clear;
  logic [15:0] load_value;
  logic        busy, expired, irq, missed;
  logic [15:0] remaining;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  tick_timer #(
    .TICKS_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .load_value (load_value),
    .irq_clear  (irq_clear),
    .busy       (busy),
    .remaining  (remaining),
    .expired    (expired),
    .irq        (irq),
    .missed     (missed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then return all pulses to idle.
  task automatic drive(input logic s, input logic st, input logic t,
                       input logic clr, input logic per, input logic [15:0] lv);
    start      = s;
    stop       = st;
    tick       = t;
    irq_clear  = clr;
    periodic   = per;
    load_value = lv;
    cyc();
    start     = 1'b0;
    stop      = 1'b0;
    tick      = 1'b0;
    irq_clear = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic b, input logic [15:0] r,
                           input logic e, input logic i, input logic m);
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".remaining"}, 32'(remaining), 32'(r));
    check({tag, ".expired"},   32'(expired),   32'(e));
    check({tag, ".irq"},       32'(irq),       32'(i));
    check({tag, ".missed"},    32'(missed),    32'(m));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    periodic = 1'b0; irq_clear = 1'b0; load_value = '0;
    cyc(); cyc();
    check_all("reset", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();

    // Zero-length start in IDLE is ignored; ticks in IDLE do nothing.
    drive(1, 0, 0, 0, 0, 16'd0);
    check_all("start0", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 16'd0);
    check_all("idle_tick", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

    // One-shot, load 3, ticks spaced 4 cycles apart.
    drive(1, 0, 0, 0, 0, 16'd3);
    check_all("os_load", 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 0, 0, 16'd0); cyc(); cyc(); cyc();
    check_all("os_t1", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 0, 0, 16'd0);
    check_all("os_t2", 1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    cyc(); cyc(); cyc();
    drive(0, 0, 1, 0, 0, 16'd0);
    check_all("os_exp", 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    cyc();
    check_all("os_after", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0, 1, 0, 16'd0);
    check_all("os_clr", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

    // Periodic, load 2, six back-to-back ticks -> three expiries.
    drive(1, 0, 0, 0, 1, 16'd2);
    check_all("per_load", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0, 16'd0);
      check("per_rem", 32'(remaining), (i % 2 == 1) ? 32'd2 : 32'd1);
      check("per_exp", 32'(expired),   (i % 2 == 1) ? 32'd1 : 32'd0);
      check("per_busy", 32'(busy), 32'd1);
      if (i == 3) check("per_missed2", 32'(missed), 32'd1);
    end
    check_all("per_end", 1'b1, 16'd2, 1'b1, 1'b1, 1'b1);

    // irq_clear alone clears both flags; then clear coincident with expiry.
    drive(0, 0, 0, 1, 0, 16'd0);
    check_all("clr_alone", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1, 0, 0, 16'd0);
    check("clr_pre", 32'(remaining), 32'd1);
    drive(0, 0, 1, 1, 0, 16'd0);
    check_all("clr_coinc", 1'b1, 16'd2, 1'b1, 1'b1, 1'b0);

    // stop + tick at remaining 1 -> no expiry, IDLE.
    drive(0, 0, 1, 0, 0, 16'd0);
    check("stop_pre", 32'(remaining), 32'd1);
    drive(0, 1, 1, 0, 0, 16'd0);
    check_all("stop_tick", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    // Retrigger: start(5) + tick in RUN -> remaining 5.
    drive(1, 0, 0, 0, 0, 16'd3);
    drive(0, 0, 1, 0, 0, 16'd0);
    check("rt_pre", 32'(remaining), 32'd2);
    drive(1, 0, 1, 0, 0, 16'd5);
    check_all("rt_tick", 1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
    // Retrigger with zero acts as stop.
    drive(1, 0, 0, 0, 0, 16'd0);
    check_all("rt_zero", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    // stop wins over start.
    drive(1, 0, 0, 0, 0, 16'd4);
    drive(1, 1, 0, 0, 0, 16'd7);
    check_all("stop_start", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

    // Reset between edges mid-RUN (remaining 4, irq pending).
    drive(1, 0, 0, 0, 0, 16'd4);
    check("rst_pre", 32'(remaining), 32'd4);
    #2 reset = 1'b1;
    #1;
    check_all("rst_mid", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    tick = 1'b1;
    reset = 1'b0;
    cyc();
    tick = 1'b0;
    check_all("rst_rel", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    check("rst_noexp", 32'(expired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
